// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_if
// Purpose  : Requester and piso-side signal bundle of the UART TX scheduler.
//            The scheduler takes the master view. The environment, meaning the
//            requesters and the piso shift register, takes the slave view.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 err;
    logic [ID_W-1:0]      grant_id;
    logic                 active;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_parity;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output ack, err, grant_id, active, tx_en, tx_data, tx_parity
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  ack, err, grant_id, active, tx_en, tx_data, tx_parity
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler that shares one UART piso among NUM_REQ
//            requesters. It latches the winner's byte and parity, runs one
//            frame at a time, acknowledges on completion, aborts frames that
//            time out, and inserts an idle gap between frames.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ       = 4,
    parameter int PARITY_ODD    = 0,
    parameter int IDLE_GAP      = 2,
    parameter int FRAME_TIMEOUT = 16
) (
    input  logic             baud_clk,
    input  logic             rstn,
    uart_tx_sched_if.master  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(FRAME_TIMEOUT);
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic             PAR_INV  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    last_grant, last_nxt;
    logic [ID_W-1:0]    grant_q, grant_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               par_q, par_nxt;
    logic               en_q, en_nxt;
    logic               act_q, act_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic               err_q, err_nxt;
    logic [TO_W-1:0]    to_cnt, to_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;

    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic [7:0]         winner_byte;

    // Round-robin pick: first set req bit above last_grant, wrapping to 0.
    always_comb begin
        any_req = 1'b0;
        winner  = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && bus.req[idx]) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
        winner_byte = bus.req_data[{winner, 3'b000} +: 8];
    end

    // Frame sequencing: next state and next values of all registered outputs.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        grant_nxt = grant_q;
        data_nxt  = data_q;
        par_nxt   = par_q;
        en_nxt    = en_q;
        act_nxt   = act_q;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        to_nxt    = to_cnt;
        gap_nxt   = gap_cnt;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = winner;
                    data_nxt  = winner_byte;
                    par_nxt   = (^winner_byte) ^ PAR_INV;
                    en_nxt    = 1'b1;
                    act_nxt   = 1'b1;
                    to_nxt    = '0;
                    state_nxt = LOAD;
                end
            end

            LOAD, SEND: begin
                // A done pulse wins over a timeout on the same edge. A done
                // pulse seen in LOAD counts as a normal completion.
                if (bus.tx_done) begin
                    en_nxt           = 1'b0;
                    act_nxt          = 1'b0;
                    ack_nxt[grant_q] = 1'b1;
                    last_nxt         = grant_q;
                    if (IDLE_GAP == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = GAP;
                    end
                end else if (to_cnt == TO_LAST) begin
                    en_nxt   = 1'b0;
                    act_nxt  = 1'b0;
                    err_nxt  = 1'b1;
                    last_nxt = grant_q;
                    // With no gap configured there is nothing to count down.
                    if (IDLE_GAP == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = GAP;
                    end
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                    if ((state == LOAD) && bus.tx_busy) begin
                        state_nxt = SEND;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers. Reset gives requester 0 first priority.
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= LAST_ID;
            grant_q    <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            en_q       <= 1'b0;
            act_q      <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
        end else begin
            last_grant <= last_nxt;
            grant_q    <= grant_nxt;
            data_q     <= data_nxt;
            par_q      <= par_nxt;
            en_q       <= en_nxt;
            act_q      <= act_nxt;
            ack_q      <= ack_nxt;
            err_q      <= err_nxt;
            to_cnt     <= to_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.grant_id  = grant_q;
    assign bus.active    = act_q;
    assign bus.tx_en     = en_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_parity = par_q;
endmodule
`default_nettype wire
